dec2bin_rx: RTL and testbench

- Receives an ASCII decimal number one character per handshake, typically from the UART receive path.
- Accumulates the digits into an unsigned binary value and emits it on a terminator character.
- This is the inbound counterpart of the binary-to-decimal display path: it turns host-typed decimal text into binary values, such as ADC thresholds and sample counts.
- One character is accepted per cycle; a result is held until the consumer takes it.

---
 rtl/dec2bin_pkg.sv | 29 ++
 rtl/dec2bin_mac10.sv | 28 ++
 rtl/dec2bin_rx.sv | 210 +++++++++++++++++++++
 tb/tb_dec2bin_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dec2bin_pkg.sv
// dec2bin_pkg: shared types, ASCII constants and character helpers for the decimal parser.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the parser state enum and character-class helpers used by dec2bin_rx.
package dec2bin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SKIP  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_term(input logic [7:0] c);
    return (c == CH_CR) || (c == CH_LF);
  endfunction

endpackage

// File: rtl/dec2bin_mac10.sv
// dec2bin_mac10: combinational multiply-by-ten-and-add for decimal accumulation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
//
// Ports:
//   acc [WIDTH-1:0] in  : running value
//   d   [3:0]       in  : next decimal digit (0..9)
//   sum [WIDTH-1:0] out : low WIDTH bits of acc*10 + d
//   ovf             out : acc*10 + d does not fit in WIDTH bits
module dec2bin_mac10 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       d,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  // Four guard bits: 10*(2^WIDTH-1)+9 < 2^(WIDTH+4), so the wide sum never wraps.
  logic [WIDTH+3:0] acc_w;
  logic [WIDTH+3:0] wide;

  assign acc_w = {4'b0000, acc};
  assign wide  = (acc_w << 3) + (acc_w << 1) + {{WIDTH{1'b0}}, d};
  assign sum   = wide[WIDTH-1:0];
  assign ovf   = |wide[WIDTH+3:WIDTH];

endmodule

// File: rtl/dec2bin_rx.sv
// dec2bin_rx: parses ASCII decimal text (one char per handshake) into a binary value.
// Latency: result valid 1 cycle after the terminator handshake.
// Backpressure: in_ready drops while a result is held; result held until out_ready.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_data: character stream (ASCII)
//   out_valid/out_ready      : result handshake
//   out_value/out_err        : binary result and error flag (overflow, >MAX_DIGITS, bad char)
//   out_ndigits              : digits consumed, saturating at 15
//   out_neg                  : only with DEC2BIN_SIGNED_EN; result came from a '-' number
// Build option: define DEC2BIN_SIGNED_EN to accept a leading '-' and emit two's complement.
module dec2bin_rx
  import dec2bin_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic             out_err,
`ifdef DEC2BIN_SIGNED_EN
  output logic             out_neg,
`endif
  output logic [3:0]       out_ndigits
);

  state_t           state, state_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [3:0]       ndig, ndig_d;
  logic             err, err_d;
  logic             ovld_d;
  logic [WIDTH-1:0] oval_d;
  logic             oerr_d;
  logic [3:0]       ond_d;

  logic             fire_in;
  logic [3:0]       dval;
  logic [3:0]       ndig_inc;
  logic [WIDTH-1:0] mac_sum;
  logic             mac_ovf;
  logic             too_big;
  logic             at_max;

  assign in_ready = (state != HOLD);
  assign fire_in  = in_valid && in_ready;
  // ASCII '0'..'9' carry the digit value in their low nibble.
  assign dval     = in_data[3:0];
  assign ndig_inc = (ndig == 4'hF) ? ndig : ndig + 4'd1;
  assign at_max   = (int'(ndig) == MAX_DIGITS);

  dec2bin_mac10 #(.WIDTH(WIDTH)) u_mac10 (
    .acc (acc),
    .d   (dval),
    .sum (mac_sum),
    .ovf (mac_ovf)
  );

`ifdef DEC2BIN_SIGNED_EN
  logic             neg, neg_d;
  logic             oneg_d;
  logic [WIDTH-1:0] mag_lim;

  // Negative numbers may reach 2^(WIDTH-1); positive ones stop one short.
  assign mag_lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign too_big = mac_ovf || (mac_sum > mag_lim);
`else
  assign too_big = mac_ovf;
`endif

  always_comb begin
    state_d = state;
    acc_d   = acc;
    ndig_d  = ndig;
    err_d   = err;
    ovld_d  = out_valid;
    oval_d  = out_value;
    oerr_d  = out_err;
    ond_d   = out_ndigits;
`ifdef DEC2BIN_SIGNED_EN
    neg_d   = neg;
    oneg_d  = out_neg;
`endif
    case (state)
      IDLE: begin
        if (fire_in) begin
          if (is_digit(in_data)) begin
            acc_d   = WIDTH'(dval);
            ndig_d  = 4'd1;
            state_d = ACCUM;
          end else if (is_term(in_data)) begin
            // Blank lines and the second half of CR/LF produce nothing.
            state_d = IDLE;
`ifdef DEC2BIN_SIGNED_EN
          end else if (in_data == CH_MINUS) begin
            neg_d   = 1'b1;
            acc_d   = '0;
            ndig_d  = 4'd0;
            state_d = ACCUM;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = SKIP;
          end
        end
      end
      ACCUM: begin
        if (fire_in) begin
          if (is_digit(in_data)) begin
            ndig_d = ndig_inc;
            if (at_max || too_big) begin
              err_d   = 1'b1;
              state_d = SKIP;
            end else begin
              acc_d = mac_sum;
            end
          end else if (is_term(in_data)) begin
            ovld_d  = 1'b1;
            ond_d   = ndig;
            state_d = HOLD;
`ifdef DEC2BIN_SIGNED_EN
            oneg_d  = neg;
            if (ndig == 4'd0) begin
              // A lone '-' is not a number.
              oval_d = '0;
              oerr_d = 1'b1;
            end else begin
              oval_d = neg ? -acc : acc;
              oerr_d = 1'b0;
            end
`else
            oval_d  = acc;
            oerr_d  = 1'b0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = SKIP;
          end
        end
      end
      SKIP: begin
        // Drain the rest of the line, still counting digits for diagnostics.
        if (fire_in) begin
          if (is_digit(in_data)) begin
            ndig_d = ndig_inc;
          end else if (is_term(in_data)) begin
            ovld_d  = 1'b1;
            oval_d  = '0;
            oerr_d  = err;
            ond_d   = ndig;
            state_d = HOLD;
`ifdef DEC2BIN_SIGNED_EN
            oneg_d  = neg;
`endif
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          ovld_d  = 1'b0;
          acc_d   = '0;
          ndig_d  = 4'd0;
          err_d   = 1'b0;
          state_d = IDLE;
`ifdef DEC2BIN_SIGNED_EN
          neg_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      ndig        <= 4'd0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      out_value   <= '0;
      out_err     <= 1'b0;
      out_ndigits <= 4'd0;
`ifdef DEC2BIN_SIGNED_EN
      neg         <= 1'b0;
      out_neg     <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      acc         <= acc_d;
      ndig        <= ndig_d;
      err         <= err_d;
      out_valid   <= ovld_d;
      out_value   <= oval_d;
      out_err     <= oerr_d;
      out_ndigits <= ond_d;
`ifdef DEC2BIN_SIGNED_EN
      neg         <= neg_d;
      out_neg     <= oneg_d;
`endif
    end
  end

endmodule

// File: tb/tb_dec2bin_rx.sv
// tb_dec2bin_rx: directed table-driven bench for dec2bin_rx plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: drives out_ready low for the stall sequence.
module tb_dec2bin_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_value;
  logic        out_err;
  logic [3:0]  out_ndigits;
`ifdef DEC2BIN_SIGNED_EN
  logic        out_neg;
`endif

  dec2bin_rx #(.WIDTH(32), .MAX_DIGITS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_err     (out_err),
`ifdef DEC2BIN_SIGNED_EN
    .out_neg     (out_neg),
`endif
    .out_ndigits (out_ndigits)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Results captured at each output handshake.
  logic [31:0] q_val[$];
  logic        q_err[$];
  logic [3:0]  q_nd[$];

  always @(negedge clk) begin
    #1;
    if (!rst && out_valid && out_ready) begin
      q_val.push_back(out_value);
      q_err.push_back(out_err);
      q_nd.push_back(out_ndigits);
    end
  end

  typedef struct packed {
    logic [127:0] txt;     // right-justified ASCII, leading NULs skipped
    logic         exp_vld; // one result expected
    logic [31:0]  val;
    logic         err;
    logic [3:0]   nd;
  } vec_t;

  vec_t vecs[12];
  int   nvec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = c;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL in_ready_timeout: got 0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input logic [127:0] t);
    for (int i = 15; i >= 0; i--) begin
      if (t[8*i +: 8] != 8'h00) send_char(t[8*i +: 8]);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_q();
    q_val.delete();
    q_err.delete();
    q_nd.delete();
  endtask

  task automatic check_one(input string name, input logic [31:0] val,
                           input logic err, input logic [3:0] nd);
    chk({name, "_count"}, 32'(q_val.size()), 32'd1);
    if (q_val.size() >= 1) begin
      chk({name, "_value"}, q_val[0], val);
      chk({name, "_err"}, 32'(q_err[0]), 32'(err));
      chk({name, "_ndigits"}, 32'(q_nd[0]), 32'(nd));
    end
  endtask

  initial begin
    int bad;

    nvec = 0;
    vecs[nvec++] = '{"1234\015",            1'b1, 32'd1234,       1'b0, 4'd4};
    vecs[nvec++] = '{"12a3\015\012",        1'b1, 32'd0,          1'b1, 4'd3};
    vecs[nvec++] = '{"\015\012\015",        1'b0, 32'd0,          1'b0, 4'd0};
    vecs[nvec++] = '{"00000000007\015",     1'b1, 32'd0,          1'b1, 4'd11};
    vecs[nvec++] = '{"0000000042\015",      1'b1, 32'd42,         1'b0, 4'd10};
    vecs[nvec++] = '{"0\012",               1'b1, 32'd0,          1'b0, 4'd1};
    vecs[nvec++] = '{"x\015",               1'b1, 32'd0,          1'b1, 4'd0};
`ifdef DEC2BIN_SIGNED_EN
    vecs[nvec++] = '{"-42\015",             1'b1, 32'hFFFF_FFD6,  1'b0, 4'd2};
    vecs[nvec++] = '{"-2147483648\015",     1'b1, 32'h8000_0000,  1'b0, 4'd10};
    vecs[nvec++] = '{"2147483648\015",      1'b1, 32'd0,          1'b1, 4'd10};
    vecs[nvec++] = '{"-\015",               1'b1, 32'd0,          1'b1, 4'd0};
`else
    vecs[nvec++] = '{"4294967295\012",      1'b1, 32'hFFFF_FFFF,  1'b0, 4'd10};
    vecs[nvec++] = '{"4294967296\012",      1'b1, 32'd0,          1'b1, 4'd10};
    vecs[nvec++] = '{"-5\015",              1'b1, 32'd0,          1'b1, 4'd1};
`endif

    // Reset state.
    wait_cycles(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_value", out_value, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_ndigits", 32'(out_ndigits), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Latency: result visible exactly one cycle after the CR handshake, for one cycle.
    clear_q();
    send_str("1234\015");
    chk("lat_out_valid_cr_plus1", 32'(out_valid), 32'd1);
    chk("lat_out_value", out_value, 32'd1234);
    chk("lat_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("lat_out_valid_one_cycle", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_in_ready_back", 32'(in_ready), 32'd1);
    check_one("lat", 32'd1234, 1'b0, 4'd4);

    // Table vectors with out_ready held high.
    for (int i = 0; i < nvec; i++) begin
      clear_q();
      send_str(vecs[i].txt);
      wait_cycles(4);
      if (vecs[i].exp_vld) begin
        check_one($sformatf("vec%0d", i), vecs[i].val, vecs[i].err, vecs[i].nd);
      end else begin
        chk($sformatf("vec%0d_no_result", i), 32'(q_val.size()), 32'd0);
      end
    end

    // Stall: result held with in_ready low while the consumer is not ready.
    clear_q();
    out_ready = 1'b0;
    send_str("55\015");
    in_valid = 1'b1;
    in_data  = "6";
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_value !== 32'd55 || out_err !== 1'b0)
        bad++;
      @(negedge clk);
    end
    chk("stall_held_cycles_bad", 32'(bad), 32'd0);
    chk("stall_no_handshake", 32'(q_val.size()), 32'd0);
    out_ready = 1'b1;
    send_str("66\015");
    wait_cycles(4);
    chk("stall_count", 32'(q_val.size()), 32'd2);
    if (q_val.size() == 2) begin
      chk("stall_first", q_val[0], 32'd55);
      chk("stall_second", q_val[1], 32'd66);
    end

    // Reset mid-number discards the partial value.
    clear_q();
    send_str("98");
    rst = 1'b1;
    wait_cycles(2);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_str("5\015");
    wait_cycles(4);
    check_one("midrst", 32'd5, 1'b0, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
